// File: rtl/shared_reg_arbiter_if.sv
// Bundle for the shared-register write port: requester handshake plus
// register observation outputs. "master" is the requester/observer side,
// "slave" is the arbiter side. Clock and reset stay outside the bundle.
//   clear       : synchronous clear of the shared register (active-high)
//   reqValid    : per-requester write request
//   reqData     : packed write data, requester i at [i*WIDTH +: WIDTH]
//   reqReady    : one-hot (or zero) grant, combinational
//   q           : shared register value
//   lastGrant   : index of the most recently committed requester
//   commitCount : number of committed writes, wraps silently
//   busy        : high for the cycle after any commit
interface shared_reg_arbiter_if #(
  parameter int NUM_REQ   = 4,
  parameter int WIDTH     = 8,
  parameter int CNT_WIDTH = 8
);
  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic                     clear;
  logic [NUM_REQ-1:0]       reqValid;
  logic [NUM_REQ*WIDTH-1:0] reqData;
  logic [NUM_REQ-1:0]       reqReady;
  logic [WIDTH-1:0]         q;
  logic [IDX_W-1:0]         lastGrant;
  logic [CNT_WIDTH-1:0]     commitCount;
  logic                     busy;

  modport master (
    output clear, reqValid, reqData,
    input  reqReady, q, lastGrant, commitCount, busy
  );

  modport slave (
    input  clear, reqValid, reqData,
    output reqReady, q, lastGrant, commitCount, busy
  );
endinterface

// File: rtl/shared_reg_arbiter.sv
// Purpose : round-robin arbiter committing one of NUM_REQ writers per cycle
//           into a single shared WIDTH-bit register.
// Latency : grant is combinational; committed data appears on q one cycle
//           after the accept edge.
// Backpressure: at most one requester sees reqReady; losers simply keep
//           valid asserted. Clear and reset force reqReady low.
// Ports   : clock, io_resetNegate (sync, active-low), io (slave modport of
//           shared_reg_arbiter_if carrying requests, grant and register state).
module shared_reg_arbiter #(
  parameter int NUM_REQ   = 4,
  parameter int WIDTH     = 8,
  parameter int CNT_WIDTH = 8
) (
  input  logic                 clock,
  input  logic                 io_resetNegate,
  shared_reg_arbiter_if.slave  io
);
  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [IDX_W:0]   NUM_REQ_W = (IDX_W+1)'(NUM_REQ);
  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(NUM_REQ - 1);

  logic [IDX_W-1:0]   pointer;
  logic [IDX_W-1:0]   grantIdx;
  logic               found;
  logic [IDX_W:0]     sum;
  logic [IDX_W-1:0]   cand;
  logic [NUM_REQ-1:0] readyVec;
  logic               accept;
  logic [WIDTH-1:0]   grantData;

  // Scan valids starting at the pointer, wrapping modulo NUM_REQ. The extra
  // sum bit keeps the wrap correct for non-power-of-two NUM_REQ.
  always_comb begin
    grantIdx = '0;
    found    = 1'b0;
    sum      = '0;
    cand     = '0;
    readyVec = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      sum = {1'b0, pointer} + (IDX_W+1)'(k);
      if (sum >= NUM_REQ_W) begin
        sum = sum - NUM_REQ_W;
      end
      cand = sum[IDX_W-1:0];
      if (!found && io.reqValid[cand]) begin
        found    = 1'b1;
        grantIdx = cand;
      end
    end
    // Reset and clear both suppress the grant so nothing looks accepted.
    if (found && io_resetNegate && !io.clear) begin
      readyVec[grantIdx] = 1'b1;
    end
  end

  assign io.reqReady = readyVec;
  assign accept      = |(readyVec & io.reqValid);
  assign grantData   = io.reqData[grantIdx*WIDTH +: WIDTH];

  // Priority: reset > clear > commit > hold.
  always_ff @(posedge clock) begin
    if (!io_resetNegate) begin
      io.q           <= '0;
      pointer        <= '0;
      io.lastGrant   <= '0;
      io.commitCount <= '0;
      io.busy        <= 1'b0;
    end else if (io.clear) begin
      io.q    <= '0;
      io.busy <= 1'b0;
    end else if (accept) begin
      io.q           <= grantData;
      io.lastGrant   <= grantIdx;
      pointer        <= (grantIdx == LAST_IDX) ? '0 : grantIdx + 1'b1;
      io.commitCount <= io.commitCount + 1'b1;
      io.busy        <= 1'b1;
    end else begin
      io.busy <= 1'b0;
    end
  end
endmodule

// File: tb/tb_shared_reg_arbiter.sv
// Directed bench for shared_reg_arbiter (NUM_REQ=4, WIDTH=8, CNT_WIDTH=8).
// Each stimulus cycle queues the grant expected for its inputs and the
// register state expected after its edge; a negedge monitor checks both.
module tb_shared_reg_arbiter;
  logic clock = 1'b0;
  logic rstn  = 1'b0;

  always #5 clock = ~clock;

  shared_reg_arbiter_if #(.NUM_REQ(4), .WIDTH(8), .CNT_WIDTH(8)) bus ();

  shared_reg_arbiter #(.NUM_REQ(4), .WIDTH(8), .CNT_WIDTH(8)) dut (
    .clock          (clock),
    .io_resetNegate (rstn),
    .io             (bus.slave)
  );

  typedef struct {
    logic [3:0] rdy;
    logic [7:0] q;
    logic [1:0] last;
    logic [7:0] cnt;
    logic       busy;
  } exp_t;

  exp_t expQ[$];
  exp_t pend;
  logic havePend = 1'b0;
  int   checks   = 0;
  int   errors   = 0;

  // Monitor: grant is checked against the record for the current inputs;
  // register state against the record of the previous cycle's edge.
  always @(negedge clock) begin
    checks++;
    if (!$onehot0(bus.reqReady)) begin
      errors++;
      $display("FAIL onehot: reqReady=%b is not at most one-hot", bus.reqReady);
    end
    if (havePend) begin
      checks++;
      if (bus.q !== pend.q) begin
        errors++;
        $display("FAIL q: got %h expected %h (t=%0t)", bus.q, pend.q, $time);
      end
      checks++;
      if (bus.lastGrant !== pend.last) begin
        errors++;
        $display("FAIL lastGrant: got %0d expected %0d (t=%0t)", bus.lastGrant, pend.last, $time);
      end
      checks++;
      if (bus.commitCount !== pend.cnt) begin
        errors++;
        $display("FAIL commitCount: got %0d expected %0d (t=%0t)", bus.commitCount, pend.cnt, $time);
      end
      checks++;
      if (bus.busy !== pend.busy) begin
        errors++;
        $display("FAIL busy: got %b expected %b (t=%0t)", bus.busy, pend.busy, $time);
      end
    end
    if (expQ.size() > 0) begin
      pend = expQ.pop_front();
      havePend = 1'b1;
      checks++;
      if (bus.reqReady !== pend.rdy) begin
        errors++;
        $display("FAIL reqReady: got %b expected %b (t=%0t)", bus.reqReady, pend.rdy, $time);
      end
    end else begin
      havePend = 1'b0;
    end
  end

  // One stimulus cycle: inputs change 1 time unit after the rising edge and
  // are committed on the following edge.
  task automatic cyc(input logic rn, input logic clr, input logic [3:0] vld,
                     input logic [31:0] dat, input logic [3:0] eRdy,
                     input logic [7:0] eQ, input logic [1:0] eLast,
                     input logic [7:0] eCnt, input logic eBusy);
    exp_t e;
    @(posedge clock);
    #1;
    rstn         = rn;
    bus.clear    = clr;
    bus.reqValid = vld;
    bus.reqData  = dat;
    e.rdy  = eRdy;
    e.q    = eQ;
    e.last = eLast;
    e.cnt  = eCnt;
    e.busy = eBusy;
    expQ.push_back(e);
  endtask

  localparam logic [31:0] D_BASE  = 32'h44332211;
  localparam logic [31:0] D_CLR   = 32'h44552211;
  localparam logic [31:0] D_RST   = 32'h4433AA11;

  initial begin
    bus.clear    = 1'b0;
    bus.reqValid = 4'b1111;
    bus.reqData  = D_BASE;

    // Reset held two cycles with every requester valid.
    cyc(1'b0, 1'b0, 4'b1111, D_BASE, 4'b0000, 8'h00, 2'd0, 8'd0, 1'b0);
    cyc(1'b0, 1'b0, 4'b1111, D_BASE, 4'b0000, 8'h00, 2'd0, 8'd0, 1'b0);

    // Round-robin rotation 0,1,2,3,0 then 1.
    cyc(1'b1, 1'b0, 4'b1111, D_BASE, 4'b0001, 8'h11, 2'd0, 8'd1, 1'b1);
    cyc(1'b1, 1'b0, 4'b1111, D_BASE, 4'b0010, 8'h22, 2'd1, 8'd2, 1'b1);
    cyc(1'b1, 1'b0, 4'b1111, D_BASE, 4'b0100, 8'h33, 2'd2, 8'd3, 1'b1);
    cyc(1'b1, 1'b0, 4'b1111, D_BASE, 4'b1000, 8'h44, 2'd3, 8'd4, 1'b1);
    cyc(1'b1, 1'b0, 4'b1111, D_BASE, 4'b0001, 8'h11, 2'd0, 8'd5, 1'b1);
    cyc(1'b1, 1'b0, 4'b1111, D_BASE, 4'b0010, 8'h22, 2'd1, 8'd6, 1'b1);

    // Pointer skip: only 0 and 3 valid after a grant to 1.
    cyc(1'b1, 1'b0, 4'b1001, D_BASE, 4'b1000, 8'h44, 2'd3, 8'd7, 1'b1);
    cyc(1'b1, 1'b0, 4'b1001, D_BASE, 4'b0001, 8'h11, 2'd0, 8'd8, 1'b1);

    // Bring q to 0x22, then clear against a write from requester 2.
    cyc(1'b1, 1'b0, 4'b0010, D_BASE, 4'b0010, 8'h22, 2'd1, 8'd9, 1'b1);
    cyc(1'b1, 1'b1, 4'b0100, D_CLR,  4'b0000, 8'h00, 2'd1, 8'd9, 1'b0);
    cyc(1'b1, 1'b0, 4'b0100, D_CLR,  4'b0100, 8'h55, 2'd2, 8'd10, 1'b1);

    // Idle: everything holds, busy drops.
    cyc(1'b1, 1'b0, 4'b0000, D_CLR,  4'b0000, 8'h55, 2'd2, 8'd10, 1'b0);

    // Reset mid-operation with requester 1 valid; afterwards 0 wins before 1.
    cyc(1'b0, 1'b0, 4'b0010, D_RST,  4'b0000, 8'h00, 2'd0, 8'd0, 1'b0);
    cyc(1'b1, 1'b0, 4'b0011, D_RST,  4'b0001, 8'h11, 2'd0, 8'd1, 1'b1);
    cyc(1'b1, 1'b0, 4'b0011, D_RST,  4'b0010, 8'hAA, 2'd1, 8'd2, 1'b1);

    // Single requester held valid: accepted every cycle, counter wraps at 256.
    for (int k = 3; k <= 256; k++) begin
      cyc(1'b1, 1'b0, 4'b0001, D_RST, 4'b0001, 8'h11, 2'd0, 8'(k), 1'b1);
    end
    cyc(1'b1, 1'b0, 4'b0000, D_RST,  4'b0000, 8'h11, 2'd0, 8'd0, 1'b0);

    // Let the monitor drain the last records.
    @(posedge clock);
    #1;
    bus.reqValid = 4'b0000;
    @(negedge clock);
    @(negedge clock);
    @(negedge clock);

    checks++;
    if (expQ.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d records unchecked, expected 0", expQ.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/shared_reg_arbiter.md
Name: shared_reg_arbiter

Overview:
- Round-robin write arbiter that shares one WIDTH-bit synchronous-reset register between NUM_REQ requesters.
- Each cycle it picks at most one valid requester, commits its data to the shared register on the clock edge, and advances the priority pointer.
- It sits in front of the sync-reset flip-flop datapath. Clients are anything that must update a single shared state word: status register, mode register, mailbox.

Parameters:
- NUM_REQ, 4, number of requesters (2..8)
- WIDTH, 8, register and data width in bits
- CNT_WIDTH, 8, width of the commit counter

Ports:
- clock  input  1  single system clock, all state updates on rising edge
- io_resetNegate  input  1  synchronous, active-low reset; sampled on rising edge of clock
- io_clear  input  1  synchronous clear of the shared register (active-high)
- io_reqValid  input  NUM_REQ  per-requester write request
- io_reqData  input  NUM_REQ*WIDTH  packed write data; requester i occupies bits [i*WIDTH +: WIDTH]
- io_reqReady  output  NUM_REQ  one-hot (or zero) grant; combinational from io_reqValid, io_clear and pointer
- io_q  output  WIDTH  current shared register value
- io_lastGrant  output  log2(NUM_REQ)  index of the most recent committed requester
- io_commitCount  output  CNT_WIDTH  number of committed writes, wraps modulo 2^CNT_WIDTH
- io_busy  output  1  high for the cycle after any commit

Behaviour:
- Reset: io_resetNegate=0 at a rising edge clears everything on that edge, and reset has priority over all other inputs.
  - io_q=0, pointer=0, io_lastGrant=0, io_commitCount=0, io_busy=0.
  - io_reqReady=0 for every cycle in which io_resetNegate=0.
- Arbitration (combinational):
  - Search io_reqValid starting at index pointer and wrapping upward mod NUM_REQ.
  - The first set bit wins, and io_reqReady has exactly that bit set.
  - No valid requester gives io_reqReady=0.
- Commit: a requester is accepted when io_reqValid[i]&io_reqReady[i] is high at a rising edge. On that edge:
  - io_q <= io_reqData[i]
  - io_lastGrant <= i
  - pointer <= (i+1) mod NUM_REQ
  - io_commitCount <= io_commitCount+1
  - io_busy <= 1
- Latency: the new value appears on io_q in the cycle after acceptance, i.e. one cycle.
- Idle: with no accept, io_q, pointer, io_lastGrant and io_commitCount hold, and io_busy <= 0.
- Clear:
  - io_clear=1 forces io_reqReady=0, so no requester is accepted.
  - On the edge, io_q <= 0.
  - pointer, io_lastGrant and io_commitCount hold; io_busy <= 0.
- Priority order: io_resetNegate=0 > io_clear=1 > commit > hold.
- Fairness:
  - A continuously asserted requester waits at most NUM_REQ-1 accept cycles.
  - A single requester held valid is accepted every cycle.
- Handshake rules:
  - Requesters may drop valid at any time without penalty; the arbiter holds no pending state per requester.
  - Data is sampled only on the accept edge.
- Counter wraps from 2^CNT_WIDTH-1 to 0 with no flag.
- Reset mid-operation: any in-flight accept on the reset edge is discarded, and the register reads 0 next cycle.
- Invariant: io_reqReady is at most one-hot at all times. The verification engineer must assert this every cycle.

Test Plan:
- Reset, then check values (NUM_REQ=4, WIDTH=8): hold io_resetNegate=0 for 2 cycles, all valid=1 -> io_reqReady=0000; after release io_q=0x00, io_commitCount=0, io_lastGrant=0.
- Round-robin rotation:
  - Stimulus: all four valid continuously, data 0x11,0x22,0x33,0x44 for requesters 0..3.
  - Required: grants 0,1,2,3,0 on successive cycles.
  - Required: io_q 0x11,0x22,0x33,0x44,0x11 one cycle after each grant.
  - Required: io_commitCount 1..5.
- Pointer skip:
  - Stimulus: after grant to 1, only requesters 0 and 3 valid.
  - Required: grant 3 first, then 0; io_lastGrant reads 3 then 0.
- Clear vs write:
  - Stimulus: io_q=0x22, requester 2 valid with 0x55, io_clear=1 in the same cycle.
  - Required: io_reqReady=0000, next io_q=0x00, io_commitCount unchanged.
  - Required: next cycle with clear=0, requester 2 is granted and io_q=0x55.
- Counter wrap: force 256 commits with CNT_WIDTH=8 -> io_commitCount returns to 0, and io_busy stays 1 throughout back-to-back commits.
- Reset mid-operation:
  - Stimulus: requester 1 valid with 0xAA and io_resetNegate=0 on the same edge.
  - Required: io_q=0x00 and pointer=0 next cycle.
  - Required: on release, requester 0 (if valid) is granted before requester 1.
